updown_cmd_sequencer: RTL and testbench
=======================================

// Module: updown_cmd_sequencer
// PURPOSE
//  Upstream command stage for the 5-bit up/down counter: turns raw push-buttons and a
//  5-bit switch bank into clean, single-cycle Load/Up/Down commands plus the IN load value.
//  Per button: 2-flop synchroniser, debounce, rising-edge pulse. Optional hold-to-repeat.
//  Feeds back counter High/Low so it never issues a command that would wrap the counter.
// PARAMETERS
//  WIDTH       5   width of Sw and IN
//  DEB_CYCLES  4   consecutive stable samples needed to accept a level change (>=1)
//  REP_DELAY   16  cycles a button is held after its first pulse before repeating starts
//  REP_PERIOD  4   cycles between repeat pulses (>=1)
// PORTS
//  CLK       in   1      clock, rising edge
//  RST       in   1      reset: one clock; reset is asynchronous and active-low
//  BtnUp     in   1      raw Up button, asynchronous, may bounce
//  BtnDown   in   1      raw Down button, asynchronous, may bounce
//  BtnLoad   in   1      raw Load button, asynchronous, may bounce
//  Sw        in   WIDTH  switch value to load; sampled only on an accepted Load
//  High      in   1      counter == 31 (from counter)
//  Low       in   1      counter == 0 (from counter)
//  Load      out  1      one-cycle load command
//  Up        out  1      one-cycle increment command
//  Down      out  1      one-cycle decrement command
//  IN        out  WIDTH  value for the counter to load; held between loads
// BEHAVIOUR
//  - Reset (RST=0, async): Load=Up=Down=0, IN=0, sync flops=0, debounced levels=0,
//    debounce and repeat counters=0, FSMs=IDLE. Reset asserted mid-press or mid-repeat
//    aborts at once. After release, a button already held must first debounce as a new press.
//  - Debounce: when the synced level differs from the debounced level for DEB_CYCLES
//    consecutive cycles, the debounced level flips. Any mismatch gap resets the count to 0.
//  - Latency: raw edge stable before CLK edge t -> pulse high for exactly one cycle
//    after edge t+DEB_CYCLES+2. Outputs are registered, with no combinational path from inputs.
//  - Load channel: debounced rising edge -> Load=1 for 1 cycle. In the same edge IN<=Sw.
//    No repeat on Load.
//  - Up/Down channel FSM (one per button): IDLE -> FIRST on debounced rise (emit pulse)
//    -> HOLD (count REP_DELAY) -> REPEAT (pulse every REP_PERIOD cycles while held).
//    Any state -> IDLE on debounced release. No pulse is emitted on release.
//  - Priority per cycle: Load > Up > Down. A lower-priority pulse that collides is dropped,
//    not queued. If Up and Down are both debounced-high, both are suppressed and both
//    FSMs hold state.
//  - Limit guard: Up forced 0 while High=1; Down forced 0 while Low=1. The FSM still
//    advances, so repeat resumes once the limit clears.
//  - At most one of Load/Up/Down is high in any cycle. All counters saturate and never wrap.
// CONFIGURATION
//  AUTO_REPEAT_EN defined: HOLD/REPEAT states are present as described above.
//  AUTO_REPEAT_EN undefined: FSM is IDLE->FIRST->(wait release)->IDLE. Exactly one
//    pulse per press; REP_DELAY and REP_PERIOD are ignored.
// TESTING (DEB_CYCLES=4, REP_DELAY=16, REP_PERIOD=4)
//  1 Reset: hold RST=0 with buttons high, release -> Load/Up/Down/IN=0.
//    First Up pulse 7 cycles after RST rises.
//  2 Bounce: BtnUp toggles every 2 cycles for 20 cycles, then stays high
//    -> exactly one Up pulse, 7 cycles after the last toggle.
//  3 Load: Sw=5'd19, press BtnLoad -> single Load pulse with IN=19 on the same cycle.
//    Then change Sw=5'd3 with no press -> IN stays 19.
//  4 Repeat (AUTO_REPEAT_EN): hold BtnUp 60 cycles after the first pulse
//    -> first pulse, next at +17, then every 4 cycles. Release -> no further pulses.
//    Without the macro -> exactly one pulse.
//  5 Limits: High=1, press BtnUp -> Up stays 0. Low=1, press BtnDown -> Down stays 0.
//    Drop High mid-hold -> repeats resume.
//  6 Conflict: BtnUp and BtnDown rise together -> no pulses.
//    BtnLoad and BtnUp accepted the same cycle -> Load only.
//    Assert RST mid-repeat -> outputs 0 immediately.

Source files
------------

// File: rtl/updown_cmd_sequencer.sv
// Command stage for the 5-bit up/down counter: debounced, edge-detected Load/Up/Down pulses.
// Define AUTO_REPEAT_EN to add hold-to-repeat (HOLD/REPEAT states) on the Up/Down buttons.
module updown_cmd_sequencer #(
  parameter int WIDTH      = 5,
  parameter int DEB_CYCLES = 4,
  parameter int REP_DELAY  = 16,
  parameter int REP_PERIOD = 4
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_btnUp,
  input  logic             i_btnDown,
  input  logic             i_btnLoad,
  input  logic [WIDTH-1:0] i_sw,
  input  logic             i_high,
  input  logic             i_low,
  output logic             o_load,
  output logic             o_up,
  output logic             o_down,
  output logic [WIDTH-1:0] o_in
);

  localparam int DW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam logic [DW-1:0] DEB_LAST = DW'(DEB_CYCLES - 1);
  localparam int REP_MAX = (REP_DELAY > REP_PERIOD) ? REP_DELAY : REP_PERIOD;
  localparam int RW = (REP_MAX > 1) ? $clog2(REP_MAX) : 1;
`ifdef AUTO_REPEAT_EN
  localparam logic [RW-1:0] DELAY_LAST  = RW'(REP_DELAY - 1);
  localparam logic [RW-1:0] PERIOD_LAST = RW'(REP_PERIOD - 1);
`endif

  typedef enum logic [1:0] {IDLE, FIRST, HOLD, REPEAT} state_t;

  // Bit 0 = Load, bit 1 = Up, bit 2 = Down
  logic [2:0]    w_raw;
  logic [2:0]    r_sync1;
  logic [2:0]    r_sync2;
  logic [2:0]    r_deb;
  logic [DW-1:0] r_debCnt [3];

  // Index 0 = Up channel, index 1 = Down channel
  state_t        r_state     [2];
  state_t        w_nextState [2];
  logic [RW-1:0] r_repCnt    [2];
  logic [RW-1:0] w_nextCnt   [2];
  logic [1:0]    w_req;
  logic [1:0]    w_debUD;
  logic          w_conflict;

  logic             r_loadPrev;
  logic             w_loadReq;
  logic             w_upFire;
  logic             w_downFire;
  logic             r_load;
  logic             r_up;
  logic             r_down;
  logic [WIDTH-1:0] r_in;

  assign w_raw = {i_btnDown, i_btnUp, i_btnLoad};

  // A level change is accepted only after DEB_CYCLES consecutive mismatching samples
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
      r_deb   <= '0;
      for (int i = 0; i < 3; i++) r_debCnt[i] <= '0;
    end else begin
      r_sync1 <= w_raw;
      r_sync2 <= r_sync1;
      for (int i = 0; i < 3; i++) begin
        if (r_sync2[i] == r_deb[i]) begin
          r_debCnt[i] <= '0;
        end else if (r_debCnt[i] == DEB_LAST) begin
          r_deb[i]    <= r_sync2[i];
          r_debCnt[i] <= '0;
        end else begin
          r_debCnt[i] <= r_debCnt[i] + 1'b1;
        end
      end
    end
  end

  assign w_debUD    = r_deb[2:1];
  assign w_conflict = r_deb[1] & r_deb[2];

  always_comb begin
    for (int ch = 0; ch < 2; ch++) begin
      w_nextState[ch] = r_state[ch];
      w_nextCnt[ch]   = r_repCnt[ch];
      w_req[ch]       = 1'b0;
      if (!w_debUD[ch]) begin
        w_nextState[ch] = IDLE;
        w_nextCnt[ch]   = '0;
      end else if (!w_conflict) begin
        unique case (r_state[ch])
          IDLE: begin
            w_req[ch]       = 1'b1;
            w_nextState[ch] = FIRST;
          end
`ifdef AUTO_REPEAT_EN
          FIRST: begin
            w_nextState[ch] = HOLD;
            w_nextCnt[ch]   = '0;
          end
          HOLD: begin
            if (r_repCnt[ch] == DELAY_LAST) begin
              w_req[ch]       = 1'b1;
              w_nextState[ch] = REPEAT;
              w_nextCnt[ch]   = '0;
            end else begin
              w_nextCnt[ch] = r_repCnt[ch] + 1'b1;
            end
          end
          REPEAT: begin
            if (r_repCnt[ch] == PERIOD_LAST) begin
              w_req[ch]     = 1'b1;
              w_nextCnt[ch] = '0;
            end else begin
              w_nextCnt[ch] = r_repCnt[ch] + 1'b1;
            end
          end
`else
          FIRST: begin
            w_nextState[ch] = FIRST;
          end
`endif
          default: begin
            w_nextState[ch] = IDLE;
            w_nextCnt[ch]   = '0;
          end
        endcase
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int ch = 0; ch < 2; ch++) begin
        r_state[ch]  <= IDLE;
        r_repCnt[ch] <= '0;
      end
    end else begin
      for (int ch = 0; ch < 2; ch++) begin
        r_state[ch]  <= w_nextState[ch];
        r_repCnt[ch] <= w_nextCnt[ch];
      end
    end
  end

  // Dropped requests are lost; the channel FSMs advance regardless of limits or priority
  assign w_loadReq  = r_deb[0] & ~r_loadPrev;
  assign w_upFire   = w_req[0] & ~w_loadReq & ~i_high;
  assign w_downFire = w_req[1] & ~w_loadReq & ~w_req[0] & ~i_low;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_loadPrev <= 1'b0;
      r_load     <= 1'b0;
      r_up       <= 1'b0;
      r_down     <= 1'b0;
      r_in       <= '0;
    end else begin
      r_loadPrev <= r_deb[0];
      r_load     <= w_loadReq;
      r_up       <= w_upFire;
      r_down     <= w_downFire;
      if (w_loadReq) r_in <= i_sw;
    end
  end

  assign o_load = r_load;
  assign o_up   = r_up;
  assign o_down = r_down;
  assign o_in   = r_in;

endmodule

// File: tb/tb_updown_cmd_sequencer.sv
// Directed bench for updown_cmd_sequencer: pulse timing, bounce, load, repeat, limits, priority, reset.
`timescale 1ns/1ps
module tb_updown_cmd_sequencer;

  localparam int WIDTH = 5;
`ifdef AUTO_REPEAT_EN
  localparam bit REPEAT_ON = 1'b1;
`else
  localparam bit REPEAT_ON = 1'b0;
`endif

  logic             clk     = 1'b0;
  logic             rst_n   = 1'b0;
  logic             btnUp   = 1'b0;
  logic             btnDown = 1'b0;
  logic             btnLoad = 1'b0;
  logic             high    = 1'b0;
  logic             low     = 1'b0;
  logic [WIDTH-1:0] sw      = '0;
  logic             load;
  logic             up;
  logic             down;
  logic [WIDTH-1:0] inVal;

  int cycleNum   = 0;
  int checkCount = 0;
  int passCount  = 0;
  int maxHot     = 0;
  int upQ[$];
  int downQ[$];
  int loadQ[$];
  int loadInQ[$];

  updown_cmd_sequencer #(
    .WIDTH(WIDTH), .DEB_CYCLES(4), .REP_DELAY(16), .REP_PERIOD(4)
  ) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_btnUp(btnUp), .i_btnDown(btnDown), .i_btnLoad(btnLoad),
    .i_sw(sw), .i_high(high), .i_low(low),
    .o_load(load), .o_up(up), .o_down(down), .o_in(inVal)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cycleNum++;

  // Pulses are logged by the index of the rising edge that produced them
  always @(negedge clk) begin
    if (up)   upQ.push_back(cycleNum);
    if (down) downQ.push_back(cycleNum);
    if (load) begin
      loadQ.push_back(cycleNum);
      loadInQ.push_back(int'(inVal));
    end
    if (int'(load) + int'(up) + int'(down) > maxHot) maxHot = int'(load) + int'(up) + int'(down);
  end

  task automatic waitCycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic applyStimulus(input logic u, input logic d, input logic l);
    btnUp   = u;
    btnDown = d;
    btnLoad = l;
  endtask

  task automatic checkOutput(input string tag, input int observed, input int expected);
    checkCount++;
    if (observed == expected) passCount++;
    else $display("[TB] FAIL %s: observed %0d, expected %0d", tag, observed, expected);
  endtask

  task automatic clearQueues();
    upQ.delete();
    downQ.delete();
    loadQ.delete();
    loadInQ.delete();
  endtask

  task automatic compareTimes(input string tag, input int got[$], input int exp[$], input int base);
    checkOutput($sformatf("%s_count", tag), got.size(), exp.size());
    for (int i = 0; i < exp.size() && i < got.size(); i++)
      checkOutput($sformatf("%s_t%0d", tag, i), got[i] - base, exp[i]);
  endtask

  initial begin
    int c;
    int expQ[$];

    $display("[TB] start, AUTO_REPEAT_EN=%0d", REPEAT_ON);

    // Reset held with Up pressed: nothing may come out until it debounces afresh
    rst_n = 1'b0;
    applyStimulus(1'b1, 1'b0, 1'b0);
    waitCycles(3);
    checkOutput("rstCmds", int'({load, up, down}), 0);
    checkOutput("rstIn", int'(inVal), 0);
    rst_n = 1'b1;
    c = cycleNum;
    clearQueues();
    waitCycles(10);
    applyStimulus(1'b0, 1'b0, 1'b0);
    waitCycles(12);
    expQ.delete(); expQ.push_back(7);
    compareTimes("rstFirstUp", upQ, expQ, c);

    // Bouncing Up button
    clearQueues();
    for (int i = 0; i < 10; i++) begin
      applyStimulus((i % 2) == 0, 1'b0, 1'b0);
      waitCycles(2);
    end
    applyStimulus(1'b1, 1'b0, 1'b0);
    c = cycleNum;
    waitCycles(14);
    applyStimulus(1'b0, 1'b0, 1'b0);
    waitCycles(12);
    expQ.delete(); expQ.push_back(7);
    compareTimes("bounceUp", upQ, expQ, c);

    // Load captures the switches and holds them
    clearQueues();
    sw = 5'd19;
    applyStimulus(1'b0, 1'b0, 1'b1);
    c = cycleNum;
    waitCycles(15);
    applyStimulus(1'b0, 1'b0, 1'b0);
    sw = 5'd3;
    waitCycles(12);
    expQ.delete(); expQ.push_back(7);
    compareTimes("loadPulse", loadQ, expQ, c);
    checkOutput("loadIn", (loadInQ.size() > 0) ? loadInQ[0] : -1, 19);
    checkOutput("inHeld", int'(inVal), 19);
    checkOutput("loadNoUp", upQ.size(), 0);

    // Long hold on Up: first pulse at +7, repeats at +17 then every 4
    clearQueues();
    applyStimulus(1'b1, 1'b0, 1'b0);
    c = cycleNum;
    waitCycles(67);
    applyStimulus(1'b0, 1'b0, 1'b0);
    waitCycles(20);
    expQ.delete(); expQ.push_back(7);
    if (REPEAT_ON) for (int k = 0; k <= 12; k++) expQ.push_back(24 + 4 * k);
    compareTimes("repeatUp", upQ, expQ, c);

    // High blocks Up; clearing it mid-hold lets repeats through
    clearQueues();
    high = 1'b1;
    applyStimulus(1'b1, 1'b0, 1'b0);
    c = cycleNum;
    waitCycles(10);
    checkOutput("highBlocksUp", upQ.size(), 0);
    waitCycles(7);
    high = 1'b0;
    waitCycles(20);
    applyStimulus(1'b0, 1'b0, 1'b0);
    waitCycles(12);
    expQ.delete();
    if (REPEAT_ON) for (int k = 0; k <= 4; k++) expQ.push_back(24 + 4 * k);
    compareTimes("highResume", upQ, expQ, c);

    // Low blocks Down, then Down works once Low clears
    clearQueues();
    low = 1'b1;
    applyStimulus(1'b0, 1'b1, 1'b0);
    waitCycles(15);
    applyStimulus(1'b0, 1'b0, 1'b0);
    waitCycles(12);
    checkOutput("lowBlocksDown", downQ.size(), 0);
    low = 1'b0;
    clearQueues();
    applyStimulus(1'b0, 1'b1, 1'b0);
    c = cycleNum;
    waitCycles(15);
    applyStimulus(1'b0, 1'b0, 1'b0);
    waitCycles(12);
    expQ.delete(); expQ.push_back(7);
    compareTimes("downPulse", downQ, expQ, c);
    checkOutput("downNoUp", upQ.size(), 0);

    // Up and Down together cancel each other
    clearQueues();
    applyStimulus(1'b1, 1'b1, 1'b0);
    waitCycles(20);
    applyStimulus(1'b0, 1'b0, 1'b0);
    waitCycles(12);
    checkOutput("conflictUp", upQ.size(), 0);
    checkOutput("conflictDown", downQ.size(), 0);

    // Load and Up accepted together: Load wins
    clearQueues();
    sw = 5'd9;
    applyStimulus(1'b1, 1'b0, 1'b1);
    c = cycleNum;
    waitCycles(15);
    applyStimulus(1'b0, 1'b0, 1'b0);
    waitCycles(12);
    expQ.delete(); expQ.push_back(7);
    compareTimes("loadWins", loadQ, expQ, c);
    checkOutput("loadWinsNoUp", upQ.size(), 0);
    checkOutput("loadWinsIn", int'(inVal), 9);

    // Asynchronous reset while an Up pulse is on the output
    clearQueues();
    applyStimulus(1'b1, 1'b0, 1'b0);
    waitCycles(REPEAT_ON ? 28 : 7);
    checkOutput("preResetUp", int'(up), 1);
    rst_n = 1'b0;
    #1;
    checkOutput("resetCmds", int'({load, up, down}), 0);
    checkOutput("resetIn", int'(inVal), 0);
    waitCycles(3);
    rst_n = 1'b1;
    c = cycleNum;
    clearQueues();
    waitCycles(10);
    applyStimulus(1'b0, 1'b0, 1'b0);
    waitCycles(12);
    expQ.delete(); expQ.push_back(7);
    compareTimes("postResetUp", upQ, expQ, c);

    checkOutput("oneHot", maxHot, 1);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
